// File: rtl/uart_ctrl.sv
// uart_ctrl: FIFO-buffered 8N1 UART with a 16x oversampled receiver and sticky error flags.
// Define UART_PARITY_EN to add a parity bit (odd/even via parity_odd) to both directions.
module uart_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 16,
  parameter int DIV_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIV_W-1:0]          baud_div,
  input  logic                      parity_odd,
  input  logic                      tx_wr_en,
  input  logic [7:0]                tx_wr_data,
  output logic                      tx_wr_ready,
  input  logic                      rx_rd_req,
  output logic [7:0]                rx_rd_data,
  output logic                      rx_rd_valid,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      rx_ovf,
  output logic                      rx_frm_err,
  output logic                      rx_par_err,
  input  logic                      err_clr,
  input  logic                      rx,
  output logic                      tx
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_st_e;

`ifdef UART_PARITY_EN
  // Parity bit giving an even total count of ones, inverted for odd parity.
  function automatic logic par_bit(input logic [7:0] data, input logic odd_sel);
    return (^data) ^ odd_sel;
  endfunction
`endif

  logic [DIV_W-1:0] tick_cnt_r;
  logic             tick_s;

  assign tick_s = (tick_cnt_r == '0);

  // Oversample tick generator; reloads from the live divisor on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= baud_div;
    end else begin
      tick_cnt_r <= tick_cnt_r - DIV_W'(1);
    end
  end

  logic [7:0]       tx_mem_r [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_r;
  logic [TX_AW-1:0] tx_rd_ptr_r;
  logic [TX_AW:0]   tx_cnt_r;
  logic             tx_push_s;
  logic             tx_pop_s;
  logic             tx_bit_end_s;
  uart_st_e         tx_st_r;
  logic             tx_r;
  logic [3:0]       tx_tick_r;
  logic [2:0]       tx_idx_r;
  logic [7:0]       tx_data_r;

  assign tx_wr_ready = (tx_cnt_r != TX_FULL);
  assign tx_push_s   = tx_wr_en & tx_wr_ready;
  assign tx_level    = tx_cnt_r;
  assign tx          = tx_r;

  // Transmitter pops only on a tick, so every bit lasts exactly 16 ticks.
  always_comb begin
    tx_bit_end_s = tick_s && (tx_tick_r == 4'd15);
    tx_pop_s     = 1'b0;
    if (tx_cnt_r != '0) begin
      if (tx_st_r == ST_IDLE) begin
        tx_pop_s = tick_s;
      end else if (tx_st_r == ST_STOP) begin
        tx_pop_s = tx_bit_end_s;
      end else begin
        tx_pop_s = 1'b0;
      end
    end else begin
      tx_pop_s = 1'b0;
    end
  end

  // TX FIFO storage.
  always_ff @(posedge clk) begin
    if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= tx_wr_data;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      tx_cnt_r    <= '0;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_AW'(1);
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_AW'(1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + (TX_AW+1)'(1);
        2'b01:   tx_cnt_r <= tx_cnt_r - (TX_AW+1)'(1);
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // Transmit FSM with registered serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_r   <= ST_IDLE;
      tx_r      <= 1'b1;
      tx_tick_r <= 4'd0;
      tx_idx_r  <= 3'd0;
      tx_data_r <= 8'd0;
    end else begin
      if ((tx_st_r != ST_IDLE) && tick_s) tx_tick_r <= tx_tick_r + 4'd1;
      case (tx_st_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (tx_pop_s) begin
            tx_st_r   <= ST_START;
            tx_r      <= 1'b0;
            tx_data_r <= tx_mem_r[tx_rd_ptr_r];
            tx_tick_r <= 4'd0;
          end
        end
        ST_START: begin
          if (tx_bit_end_s) begin
            tx_st_r  <= ST_DATA;
            tx_r     <= tx_data_r[0];
            tx_idx_r <= 3'd0;
          end
        end
        ST_DATA: begin
          if (tx_bit_end_s) begin
            if (tx_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_st_r <= ST_PARITY;
              tx_r    <= par_bit(tx_data_r, parity_odd);
`else
              tx_st_r <= ST_STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              tx_idx_r <= tx_idx_r + 3'd1;
              tx_r     <= tx_data_r[tx_idx_r + 3'd1];
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tx_bit_end_s) begin
            tx_st_r <= ST_STOP;
            tx_r    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tx_bit_end_s) begin
            if (tx_pop_s) begin
              tx_st_r   <= ST_START;
              tx_r      <= 1'b0;
              tx_data_r <= tx_mem_r[tx_rd_ptr_r];
            end else begin
              tx_st_r <= ST_IDLE;
              tx_r    <= 1'b1;
            end
          end
        end
        default: begin
          tx_st_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;
  uart_st_e         rx_st_r;
  logic [3:0]       rx_tick_r;
  logic [2:0]       rx_idx_r;
  logic [7:0]       rx_data_r;
  logic             rx_bit_end_s;
  logic             rx_store_s;
  logic             frm_set_s;
  logic             ovf_set_s;
  logic [7:0]       rx_mem_r [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_r;
  logic [RX_AW-1:0] rx_rd_ptr_r;
  logic [RX_AW:0]   rx_cnt_r;
  logic             rx_full_s;
  logic             rx_push_s;
  logic             rx_pop_s;
  logic [7:0]       rx_rd_data_r;
  logic             rx_rd_valid_r;
  logic             rx_ovf_r;
  logic             rx_frm_err_r;

  // Two-flop synchroniser plus a history flop for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Mid-bit sample points and the resulting store / error events.
  always_comb begin
    rx_bit_end_s = tick_s && (rx_tick_r == 4'd15);
    rx_store_s   = (rx_st_r == ST_STOP) && rx_bit_end_s && rx_sync_r;
    frm_set_s    = (rx_st_r == ST_STOP) && rx_bit_end_s && !rx_sync_r;
    rx_full_s    = (rx_cnt_r == RX_FULL);
    rx_pop_s     = rx_rd_req && (rx_cnt_r != '0);
    rx_push_s    = rx_store_s && (!rx_full_s || rx_pop_s);
    ovf_set_s    = rx_store_s && rx_full_s && !rx_pop_s;
  end

  // Receive FSM: centre on the start bit, then sample every 16 ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_r   <= ST_IDLE;
      rx_tick_r <= 4'd0;
      rx_idx_r  <= 3'd0;
      rx_data_r <= 8'd0;
    end else begin
      if ((rx_st_r != ST_IDLE) && tick_s) rx_tick_r <= rx_tick_r + 4'd1;
      case (rx_st_r)
        ST_IDLE: begin
          if (rx_prev_r && !rx_sync_r) begin
            rx_st_r   <= ST_START;
            rx_tick_r <= 4'd0;
          end
        end
        ST_START: begin
          if (tick_s && (rx_tick_r == 4'd7)) begin
            rx_tick_r <= 4'd0;
            rx_idx_r  <= 3'd0;
            rx_st_r   <= rx_sync_r ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_bit_end_s) begin
            rx_data_r[rx_idx_r] <= rx_sync_r;
            rx_idx_r            <= rx_idx_r + 3'd1;
            if (rx_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_st_r <= ST_PARITY;
`else
              rx_st_r <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (rx_bit_end_s) rx_st_r <= ST_STOP;
        end
`endif
        ST_STOP: begin
          if (rx_bit_end_s) rx_st_r <= ST_IDLE;
        end
        default: rx_st_r <= ST_IDLE;
      endcase
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data_r;
  end

  // RX FIFO pointers, occupancy and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr_r   <= '0;
      rx_rd_ptr_r   <= '0;
      rx_cnt_r      <= '0;
      rx_rd_data_r  <= 8'd0;
      rx_rd_valid_r <= 1'b0;
    end else begin
      rx_rd_valid_r <= rx_pop_s;
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_AW'(1);
      if (rx_pop_s) begin
        rx_rd_ptr_r  <= rx_rd_ptr_r + RX_AW'(1);
        rx_rd_data_r <= rx_mem_r[rx_rd_ptr_r];
      end
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + (RX_AW+1)'(1);
        2'b01:   rx_cnt_r <= rx_cnt_r - (RX_AW+1)'(1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase
    end
  end

  // Sticky error flags; a new event outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ovf_r     <= 1'b0;
      rx_frm_err_r <= 1'b0;
    end else begin
      rx_ovf_r     <= ovf_set_s | (rx_ovf_r & ~err_clr);
      rx_frm_err_r <= frm_set_s | (rx_frm_err_r & ~err_clr);
    end
  end

`ifdef UART_PARITY_EN
  logic rx_par_err_r;
  logic par_set_s;

  assign par_set_s = (rx_st_r == ST_PARITY) && rx_bit_end_s &&
                     (rx_sync_r != par_bit(rx_data_r, parity_odd));

  // Sticky parity flag, same set-over-clear priority as the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_par_err_r <= 1'b0;
    end else begin
      rx_par_err_r <= par_set_s | (rx_par_err_r & ~err_clr);
    end
  end

  assign rx_par_err = rx_par_err_r;
`else
  logic unused_parity_s;

  assign unused_parity_s = parity_odd;
  assign rx_par_err      = 1'b0;
`endif

  assign rx_rd_data  = rx_rd_data_r;
  assign rx_rd_valid = rx_rd_valid_r;
  assign rx_level    = rx_cnt_r;
  assign rx_ovf      = rx_ovf_r;
  assign rx_frm_err  = rx_frm_err_r;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: random bytes through a loopback, compared with a
// queue-based model of the RX FIFO and a bit-list model of the serial frame.
module tb_uart_ctrl;

  localparam int DW = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] baud_div = 16'd3;
  logic          parity_odd = 1'b0;
  logic          tx_wr_en = 1'b0;
  logic [7:0]    tx_wr_data = 8'd0;
  logic          tx_wr_ready;
  logic          rx_rd_req = 1'b0;
  logic [7:0]    rx_rd_data;
  logic          rx_rd_valid;
  logic [3:0]    tx_level;
  logic [4:0]    rx_level;
  logic          rx_ovf, rx_frm_err, rx_par_err;
  logic          err_clr = 1'b0;
  logic          rx, tx;
  logic          loop_en = 1'b0;
  logic          rx_drv = 1'b1;

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_ctrl #(.TX_DEPTH(8), .RX_DEPTH(16), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_odd(parity_odd),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_wr_ready(tx_wr_ready),
    .rx_rd_req(rx_rd_req), .rx_rd_data(rx_rd_data), .rx_rd_valid(rx_rd_valid),
    .tx_level(tx_level), .rx_level(rx_level), .rx_ovf(rx_ovf),
    .rx_frm_err(rx_frm_err), .rx_par_err(rx_par_err), .err_clr(err_clr),
    .rx(rx), .tx(tx)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    exp_q [$];
  logic          exp_ovf;
  int            exp_tx_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level of bit k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k, input logic odd);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[3'(k-1)];
    if (NB == 11 && k == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    tx_wr_en   = 1'b1;
    tx_wr_data = b;
    @(negedge clk);
    tx_wr_en   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_b);
    rx_rd_req = 1'b1;
    @(negedge clk);
    rx_rd_req = 1'b0;
    check_val({tag, "_valid"}, rx_rd_valid, 1);
    check_val({tag, "_data"}, rx_rd_data, exp_b);
  endtask

  task automatic model_store(input logic [7:0] b);
    if (exp_q.size() < 16) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while (tx_level != 4'd0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_drain", tx_level, 0);
    repeat (200) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1) rx_drv = stop;
      else if (NB == 11 && k == 9) rx_drv = par;
      else rx_drv = frame_bit(b, k, 1'b0);
      repeat (16 * (int'(baud_div) + 1)) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         n, low_run, errs;
    bit         still_low;
    exp_ovf = 1'b0;

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_ready", tx_wr_ready, 1);
    check_val("rst_valid", rx_rd_valid, 0);
    check_val("rst_rdata", rx_rd_data, 0);
    check_val("rst_levels", {tx_level, rx_level}, 0);
    check_val("rst_flags", {rx_ovf, rx_frm_err, rx_par_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Exact TX waveform for 0xA5 at baud_div=3 (64 clk per bit).
    push(8'hA5);
    n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("tx_start_seen", tx, 0);
    low_run = 0; errs = 0; still_low = 1'b1;
    for (int k = 0; k < NB * 64; k++) begin
      if (still_low && tx === 1'b0) low_run++;
      else still_low = 1'b0;
      if (tx !== frame_bit(8'hA5, k / 64, parity_odd)) errs++;
      @(negedge clk);
    end
    check_val("tx_start_len", low_run, 64);
    check_val("tx_wave_errs", errs, 0);
    check_val("tx_idle_after", tx, 1);

    // Loopback of 0x3C and the registered pop handshake.
    baud_div = 16'd0;
    loop_en  = 1'b1;
    push(8'h3C);
    model_store(8'h3C);
    wait_tx_drain();
    check_val("lb_level", rx_level, exp_q.size());
    pop_check("lb_pop", exp_q.pop_front());
    check_val("lb_level_after", rx_level, 0);
    @(negedge clk);
    check_val("lb_valid_drop", rx_rd_valid, 0);
    rx_rd_req = 1'b1;
    @(negedge clk);
    rx_rd_req = 1'b0;
    check_val("empty_pop_valid", rx_rd_valid, 0);
    check_val("empty_pop_level", rx_level, 0);

    // Random bytes with random parity sense.
    parity_odd = 1'($urandom_range(0, 1));
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      push(b);
      model_store(b);
    end
    wait_tx_drain();
    check_val("rnd_level", rx_level, exp_q.size());
    check_val("rnd_par_err", rx_par_err, 0);
    for (int i = 0; i < 6; i++) pop_check("rnd_pop", exp_q.pop_front());

    // 17 bytes without reads: overflow, first 16 kept in order.
    for (int i = 0; i < 17; i++) begin
      n = 0;
      while (!tx_wr_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      check_val("tx_ready_wait", tx_wr_ready, 1);
      b = 8'($urandom);
      push(b);
      model_store(b);
    end
    wait_tx_drain();
    check_val("ovf_flag", rx_ovf, exp_ovf);
    check_val("ovf_level", rx_level, exp_q.size());
    for (int i = 0; i < 16; i++) pop_check("ovf_pop", exp_q.pop_front());
    clear_errs();
    check_val("ovf_cleared", rx_ovf, 0);

    // Framing error, then a short glitch, then a good frame.
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (20) @(negedge clk);
    b = 8'($urandom);
    send_frame(b, (^b) ^ parity_odd, 1'b0);
    repeat (32) @(negedge clk);
    check_val("frm_flag", rx_frm_err, 1);
    check_val("frm_level", rx_level, 0);
    clear_errs();
    check_val("frm_cleared", rx_frm_err, 0);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_val("glitch_level", rx_level, 0);
    check_val("glitch_flags", {rx_frm_err, rx_ovf, rx_par_err}, 0);
    b = 8'($urandom);
    send_frame(b, (^b) ^ parity_odd, 1'b1);
    repeat (32) @(negedge clk);
    check_val("good_level", rx_level, 1);
    pop_check("good_pop", b);

`ifdef UART_PARITY_EN
    // Even parity, 0x07 with a wrong parity bit: flagged yet stored.
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    check_val("par_flag", rx_par_err, 1);
    check_val("par_level", rx_level, 1);
    pop_check("par_pop", 8'h07);
    clear_errs();
    check_val("par_cleared", rx_par_err, 0);
`else
    check_val("par_tied", rx_par_err, 0);
`endif

    // TX busy on a slow baud: fill the FIFO, drop the ninth push.
    baud_div = 16'd100;
    push(8'h11);
    n = 0;
    while (tx_level != 4'd0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("busy_popped", tx_level, 0);
    exp_tx_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      push(8'($urandom));
      if (exp_tx_cnt < 8) exp_tx_cnt++;
      if (i == 7) check_val("full_ready", tx_wr_ready, 0);
    end
    check_val("full_level", tx_level, exp_tx_cnt);
    check_val("busy_tx_low", tx, 0);

    // Reset mid-frame on both directions.
    rx_drv = 1'b0;
    repeat (2000) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_tx", tx, 1);
    check_val("midrst_levels", {tx_level, rx_level}, 0);
    check_val("midrst_ready", tx_wr_ready, 1);
    rx_drv = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    baud_div = 16'd0;
    repeat (300) @(negedge clk);
    check_val("post_rst_rx_level", rx_level, 0);
    check_val("post_rst_tx_idle", tx, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
